heap_sort_unpacker: RTL and testbench

Downstream stage of the heap-sort top entity. Accepts the 161-bit sorted frame (valid flag plus five 32-bit keys), buffers it in a small frame FIFO, and emits the keys one per cycle on a valid/ready stream with index and last markers. The sorter has no backpressure input, so this block absorbs frame bursts and flags any frame it has to drop.

---
 rtl/heap_sort_pkg.sv | 19 +
 rtl/heap_sort_frame_fifo.sv | 76 +++++++
 rtl/heap_sort_unpacker.sv | 133 +++++++++++++
 tb/tb_heap_sort_unpacker.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/heap_sort_pkg.sv
// Shared constants, key/frame types and serializer states for the heap-sort output stage.
package heap_sort_pkg;

    localparam int KEY_W   = 32;
    localparam int N_KEYS  = 5;
    localparam int FRAME_W = N_KEYS * KEY_W;
    localparam int IN_W    = FRAME_W + 1;

    typedef logic [KEY_W-1:0] key_t;

    // Element N_KEYS-1 sits in the MSBs, so it is key 0 of the sorted frame.
    typedef key_t [N_KEYS-1:0] frame_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } ser_state_t;

endpackage

// File: rtl/heap_sort_frame_fifo.sv
// Small frame FIFO: DEPTH entries of WIDTH bits, count-based full/empty,
// head visible on dout, write accepted on a full FIFO when a pop happens alongside.
module heap_sort_frame_fifo #(
    parameter int WIDTH = 160,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             wr_en_s;
    logic             rd_en_s;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == LAST_PTR) begin
            ptr_inc = {PTR_W{1'b0}};
        end else begin
            ptr_inc = p + PTR_W'(1);
        end
    endfunction

    assign full  = (count_r == FULL_CNT);
    assign empty = (count_r == {CNT_W{1'b0}});
    assign dout  = mem_r[rd_ptr_r];

    // Qualify the raw requests: a pop frees the slot a simultaneous push needs.
    always_comb begin
        wr_en_s = push & (~full | pop);
        rd_en_s = pop & ~empty;
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (rd_en_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/heap_sort_unpacker.sv
// Downstream stage of the heap sorter: buffers sorted frames and streams
// their keys one per cycle (key 0 first) with index/last markers. Frames
// arriving on a full FIFO with no pop are dropped and counted.
module heap_sort_unpacker #(
    parameter int KEY_W  = heap_sort_pkg::KEY_W,
    parameter int N_KEYS = heap_sort_pkg::N_KEYS,
    parameter int DEPTH  = 2
) (
    input  logic                  system1000,
    input  logic                  system1000_rst,
    input  logic [N_KEYS*KEY_W:0] in_frame,
    output logic [KEY_W-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2:0]            out_index,
    output logic                  out_last,
    output logic                  overflow,
    output logic [7:0]            drop_count
);

    import heap_sort_pkg::*;

    localparam int FRM_W = N_KEYS * KEY_W;
    localparam logic [2:0] LAST_IDX = 3'(N_KEYS - 1);

    ser_state_t       state_r;
    logic [FRM_W-1:0] frame_r;
    logic [FRM_W-1:0] fifo_dout_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic             push_s;
    logic             pop_s;
    logic             hs_s;
    logic             drop_s;

    assign push_s = in_frame[FRM_W];

    // The current key always sits in the top slot of the shifting frame register.
    assign out_data = frame_r[FRM_W-1 -: KEY_W];

    heap_sort_frame_fifo #(
        .WIDTH (FRM_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (system1000),
        .rst   (system1000_rst),
        .push  (push_s),
        .pop   (pop_s),
        .din   (in_frame[FRM_W-1:0]),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Decide when the serializer takes the FIFO head and whether an input frame is lost.
    always_comb begin
        hs_s  = out_valid & out_ready;
        pop_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s = 1'b1;
                end else begin
                    pop_s = 1'b0;
                end
            end
            EMIT: begin
                // Reloading on the last handshake keeps back-to-back frames gapless.
                if (hs_s && (out_index == LAST_IDX) && !fifo_empty_s) begin
                    pop_s = 1'b1;
                end else begin
                    pop_s = 1'b0;
                end
            end
            default: pop_s = 1'b0;
        endcase
        drop_s = push_s & fifo_full_s & ~pop_s;
    end

    // Serializer: load a frame, shift one key out per handshake, return to idle when drained.
    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            state_r   <= IDLE;
            frame_r   <= {FRM_W{1'b0}};
            out_valid <= 1'b0;
            out_index <= 3'd0;
            out_last  <= 1'b0;
        end else if (pop_s) begin
            state_r   <= EMIT;
            frame_r   <= fifo_dout_s;
            out_valid <= 1'b1;
            out_index <= 3'd0;
            out_last  <= (LAST_IDX == 3'd0);
        end else if (hs_s && (out_index != LAST_IDX)) begin
            state_r   <= EMIT;
            frame_r   <= frame_r << KEY_W;
            out_valid <= 1'b1;
            out_index <= out_index + 3'd1;
            out_last  <= ((out_index + 3'd1) == LAST_IDX);
        end else if (hs_s) begin
            state_r   <= IDLE;
            frame_r   <= frame_r;
            out_valid <= 1'b0;
            out_index <= 3'd0;
            out_last  <= 1'b0;
        end else begin
            state_r   <= state_r;
            frame_r   <= frame_r;
            out_valid <= out_valid;
            out_index <= out_index;
            out_last  <= out_last;
        end
    end

    // Sticky overflow flag and saturating count of dropped frames.
    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            overflow   <= 1'b0;
            drop_count <= 8'd0;
        end else if (drop_s) begin
            overflow <= 1'b1;
            if (drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
            end else begin
                drop_count <= drop_count;
            end
        end else begin
            overflow   <= overflow;
            drop_count <= drop_count;
        end
    end

endmodule

// File: tb/tb_heap_sort_unpacker.sv
// Directed bench for heap_sort_unpacker: stimulus pushes expected keys into a
// queue, an independent monitor pops and compares on every output handshake.
module tb_heap_sort_unpacker;

    localparam int KEY_W  = 32;
    localparam int N_KEYS = 5;
    localparam int DEPTH  = 2;

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  index;
        logic        last;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [N_KEYS*KEY_W:0] in_frame;
    logic [KEY_W-1:0]      out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [2:0]            out_index;
    logic                  out_last;
    logic                  overflow;
    logic [7:0]            drop_count;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          hs_total = 0;
    int          hs_mark;
    bit          mon_stall = 1'b0;
    logic [31:0] held_data;
    logic [2:0]  held_index;
    logic        held_last;
    bit          found;
    int          guard;

    heap_sort_unpacker #(
        .KEY_W  (KEY_W),
        .N_KEYS (N_KEYS),
        .DEPTH  (DEPTH)
    ) dut (
        .system1000     (clk),
        .system1000_rst (rst),
        .in_frame       (in_frame),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_index      (out_index),
        .out_last       (out_last),
        .overflow       (overflow),
        .drop_count     (drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one frame with keys base..base+4 for one cycle.
    task automatic push_frame(input logic [31:0] base, input bit accept);
        exp_t e;
        in_frame = {1'b1, base, base + 32'd1, base + 32'd2, base + 32'd3, base + 32'd4};
        if (accept) begin
            for (int i = 0; i < N_KEYS; i++) begin
                e.data  = base + 32'(i);
                e.index = 3'(i);
                e.last  = (i == N_KEYS - 1);
                exp_q.push_back(e);
            end
        end
        tick();
        in_frame = '0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < budget) begin
            tick();
            n++;
        end
        chk("drain_timeout", 32'(n < budget), 32'd1);
    endtask

    // Scoreboard monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (mon_stall) begin
                chk("stall_data", out_data, held_data);
                chk("stall_index", 32'(out_index), 32'(held_index));
                chk("stall_last", 32'(out_last), 32'(held_last));
            end
            if (out_ready) begin
                hs_total++;
                mon_stall = 1'b0;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_key: actual %0h required none", out_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("key_data", out_data, mon_e.data);
                    chk("key_index", 32'(out_index), 32'(mon_e.index));
                    chk("key_last", 32'(out_last), 32'(mon_e.last));
                end
            end else begin
                mon_stall  = 1'b1;
                held_data  = out_data;
                held_index = out_index;
                held_last  = out_last;
            end
        end else begin
            mon_stall = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        in_frame  = '0;
        out_ready = 1'b0;
        tick();
        tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_index", 32'(out_index), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_drop_count", 32'(drop_count), 32'd0);
        rst = 1'b0;
        tick();

        // Single frame: key 0 at t+2, key 4 at t+6, idle afterwards.
        out_ready = 1'b1;
        push_frame(32'd1, 1'b1);
        chk("lat_t1_valid", 32'(out_valid), 32'd0);
        tick();
        chk("lat_t2_valid", 32'(out_valid), 32'd1);
        chk("lat_t2_index", 32'(out_index), 32'd0);
        for (int i = 1; i < N_KEYS; i++) begin
            tick();
            chk("single_contig", 32'(out_valid), 32'd1);
        end
        chk("lat_t6_index", 32'(out_index), 32'd4);
        tick();
        chk("single_idle", 32'(out_valid), 32'd0);
        wait_drain(20);

        // Backpressure with ready pattern 1,0,0,1 repeating.
        out_ready = 1'b0;
        push_frame(32'hA, 1'b1);
        for (int c = 0; c < 40; c++) begin
            out_ready = ((c % 4) == 0) || ((c % 4) == 3);
            tick();
        end
        out_ready = 1'b1;
        wait_drain(20);

        // Back-to-back frames five cycles apart: ten keys with no gap.
        out_ready = 1'b1;
        push_frame(32'd1, 1'b1);
        tick();
        for (int c = 2; c < 12; c++) begin
            chk("b2b_contig", 32'(out_valid), 32'd1);
            if (c == 5) begin
                push_frame(32'd6, 1'b1);
            end else begin
                tick();
            end
        end
        chk("b2b_idle", 32'(out_valid), 32'd0);
        wait_drain(20);

        // Overflow: four frames in a row with the consumer stalled.
        out_ready = 1'b0;
        push_frame(32'h100, 1'b1);
        push_frame(32'h200, 1'b1);
        push_frame(32'h300, 1'b1);
        chk("ovf_before", 32'(overflow), 32'd0);
        push_frame(32'h400, 1'b0);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_drop_count", 32'(drop_count), 32'd1);
        hs_mark   = hs_total;
        out_ready = 1'b1;
        wait_drain(60);
        chk("ovf_emitted_keys", 32'(hs_total - hs_mark), 32'd15);

        // Push on a full FIFO in the same cycle as the last-key handshake.
        out_ready = 1'b0;
        push_frame(32'h500, 1'b1);
        push_frame(32'h600, 1'b1);
        push_frame(32'h700, 1'b1);
        tick();
        chk("full_drop_before", 32'(drop_count), 32'd1);
        out_ready = 1'b1;
        found     = 1'b0;
        guard     = 0;
        while (!found && guard < 20) begin
            if (out_valid && out_last) begin
                found = 1'b1;
            end else begin
                tick();
                guard++;
            end
        end
        chk("full_found_last", 32'(found), 32'd1);
        push_frame(32'h800, 1'b1);
        chk("full_no_drop", 32'(drop_count), 32'd1);
        chk("full_overflow_sticky", 32'(overflow), 32'd1);
        wait_drain(60);

        // Reset mid-frame at index 2.
        out_ready = 1'b1;
        push_frame(32'h900, 1'b1);
        found = 1'b0;
        guard = 0;
        while (!found && guard < 20) begin
            if (out_valid && out_index == 3'd2) begin
                found = 1'b1;
            end else begin
                tick();
                guard++;
            end
        end
        chk("mid_found_idx2", 32'(found), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_last", 32'(out_last), 32'd0);
        chk("mid_rst_index", 32'(out_index), 32'd0);
        chk("mid_rst_data", out_data, 32'd0);
        chk("mid_rst_overflow", 32'(overflow), 32'd0);
        chk("mid_rst_drop_count", 32'(drop_count), 32'd0);
        tick();
        chk("mid_no_resume", 32'(out_valid), 32'd0);
        push_frame(32'h1000, 1'b1);
        tick();
        chk("mid_restart_valid", 32'(out_valid), 32'd1);
        chk("mid_restart_index", 32'(out_index), 32'd0);
        wait_drain(20);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
